// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - CPU, DMA and RAM-side signal bundle for the RGB RAM port arbiter
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 24
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [2:0]        cpu_byteena;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [2:0]        dma_byteena;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [2:0]        ram_byteena;
    logic [DATA_W-1:0] ram_q;

    // Requesters and the RAM macro sit on the master side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byteena,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_byteena,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  ram_addr, ram_wdata, ram_wren, ram_byteena,
        output ram_q
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byteena,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_byteena,
        output dma_gnt, dma_rvalid, dma_rdata,
        output ram_addr, ram_wdata, ram_wren, ram_byteena,
        input  ram_q
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - CPU-priority arbiter for the single-port RGB RAM with DMA starvation guard
module ram_port_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 24,
    parameter int STARVE_MAX = 8
) (
    input logic              clk,
    input logic              rst,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic {
        NORMAL = 1'b0,
        FORCED = 1'b1
    } state_t;

    localparam logic [7:0] STARVE_LAST = 8'(STARVE_MAX - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        starve_cnt;
    logic [7:0]        starve_cnt_nxt;
    logic              cpu_win;
    logic              dma_win;
    logic [1:0]        rd_tag;
    logic [1:0]        rd_tag_nxt;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] dma_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= NORMAL;
            starve_cnt <= 8'd0;
            rd_tag     <= 2'b00;
            cpu_hold   <= '0;
            dma_hold   <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            rd_tag     <= rd_tag_nxt;
            if (rd_tag[1]) cpu_hold <= bus.ram_q;
            if (rd_tag[0]) dma_hold <= bus.ram_q;
        end
    end

    always_comb begin
        state_nxt      = NORMAL;
        starve_cnt_nxt = 8'd0;
        cpu_win        = 1'b0;
        dma_win        = 1'b0;

        case (state)
            FORCED: begin
                dma_win = bus.dma_req;
                cpu_win = bus.cpu_req && !bus.dma_req;
            end
            default: begin
                cpu_win = bus.cpu_req;
                dma_win = !bus.cpu_req && bus.dma_req;
            end
        endcase

        // Nothing is granted while reset is held, so the RAM never sees a write.
        if (!rst) begin
            cpu_win = 1'b0;
            dma_win = 1'b0;
        end

        if (bus.dma_req && !dma_win) begin
            if (starve_cnt == STARVE_LAST) begin
                state_nxt = FORCED;
            end else begin
                starve_cnt_nxt = starve_cnt + 8'd1;
            end
        end

        rd_tag_nxt = {cpu_win && !bus.cpu_we, dma_win && !bus.dma_we};
    end

    // A CPU request can only lose to the DMA in the forced slot.
    assign bus.cpu_stall = bus.cpu_req && dma_win;
    assign bus.dma_gnt   = dma_win;

    assign bus.ram_addr  = dma_win ? bus.dma_addr  : bus.cpu_addr;
    assign bus.ram_wdata = dma_win ? bus.dma_wdata : bus.cpu_wdata;

    always_comb begin
        bus.ram_wren    = 1'b0;
        bus.ram_byteena = 3'b000;
        if (cpu_win) begin
            bus.ram_wren    = bus.cpu_we;
            bus.ram_byteena = bus.cpu_we ? bus.cpu_byteena : 3'b111;
        end else if (dma_win) begin
            bus.ram_wren    = bus.dma_we;
            bus.ram_byteena = bus.dma_we ? bus.dma_byteena : 3'b111;
        end
    end

    // The RAM output is shared; each requester keeps its last returned word.
    assign bus.cpu_rvalid = rd_tag[1];
    assign bus.dma_rvalid = rd_tag[0];
    assign bus.cpu_rdata  = rd_tag[1] ? bus.ram_q : cpu_hold;
    assign bus.dma_rdata  = rd_tag[0] ? bus.ram_q : dma_hold;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter with RAM model and reference model
module tb_ram_port_arbiter;
    localparam int ADDR_W     = 18;
    localparam int DATA_W     = 24;
    localparam int STARVE_MAX = 8;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // RAM macro: registered read, byte-lane writes, read-during-write returns old data.
    logic [DATA_W-1:0] ram_mem [0:1023];
    always @(posedge clk) begin
        bus.ram_q <= ram_mem[bus.ram_addr[9:0]];
        if (bus.ram_wren) begin
            for (int i = 0; i < 3; i++)
                if (bus.ram_byteena[i]) ram_mem[bus.ram_addr[9:0]][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: the DMA has waited m_wait denied cycles; once that equals STARVE_MAX it wins.
    int                m_wait;
    logic              m_pc, m_pd;
    logic [DATA_W-1:0] m_pcd, m_pdd, m_ch, m_dh;
    logic [DATA_W-1:0] smem [0:1023];
    logic              e_dw, e_cw, e_wren;
    logic [2:0]        e_be;
    logic [DATA_W-1:0] e_cr, e_dr;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
            chk("rst_dma_gnt", 32'(bus.dma_gnt), 32'd0);
            chk("rst_ram_wren", 32'(bus.ram_wren), 32'd0);
            chk("rst_ram_byteena", 32'(bus.ram_byteena), 32'd0);
            chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
            chk("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
            chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
            chk("rst_dma_rdata", 32'(bus.dma_rdata), 32'd0);
            m_wait = 0; m_pc = 0; m_pd = 0; m_ch = '0; m_dh = '0;
        end else begin
            e_dw = bus.dma_req && (!bus.cpu_req || m_wait == STARVE_MAX);
            e_cw = bus.cpu_req && !e_dw;
            e_wren = (e_cw && bus.cpu_we) || (e_dw && bus.dma_we);
            e_be = e_cw ? (bus.cpu_we ? bus.cpu_byteena : 3'b111)
                 : e_dw ? (bus.dma_we ? bus.dma_byteena : 3'b111) : 3'b000;
            e_cr = m_pc ? m_pcd : m_ch;
            e_dr = m_pd ? m_pdd : m_dh;
            chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && e_dw));
            chk("dma_gnt", 32'(bus.dma_gnt), 32'(e_dw));
            chk("ram_wren", 32'(bus.ram_wren), 32'(e_wren));
            chk("ram_byteena", 32'(bus.ram_byteena), 32'(e_be));
            chk("ram_addr", 32'(bus.ram_addr), 32'(e_dw ? bus.dma_addr : bus.cpu_addr));
            chk("ram_wdata", 32'(bus.ram_wdata), 32'(e_dw ? bus.dma_wdata : bus.cpu_wdata));
            chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_pc));
            chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(m_pd));
            chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_cr));
            chk("dma_rdata", 32'(bus.dma_rdata), 32'(e_dr));
            m_ch = e_cr;
            m_dh = e_dr;
            m_pc = e_cw && !bus.cpu_we;
            m_pd = e_dw && !bus.dma_we;
            m_pcd = smem[bus.cpu_addr[9:0]];
            m_pdd = smem[bus.dma_addr[9:0]];
            if (e_wren) begin
                for (int i = 0; i < 3; i++)
                    if (e_be[i]) smem[e_cw ? bus.cpu_addr[9:0] : bus.dma_addr[9:0]][8*i +: 8]
                        = e_cw ? bus.cpu_wdata[8*i +: 8] : bus.dma_wdata[8*i +: 8];
            end
            m_wait = (bus.dma_req && !e_dw) ? m_wait + 1 : 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_cpu(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data, input logic [2:0] be);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr;
        bus.cpu_wdata = data; bus.cpu_byteena = be;
    endtask

    task automatic drive_dma(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data, input logic [2:0] be);
        bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr;
        bus.dma_wdata = data; bus.dma_byteena = be;
    endtask

    task automatic idle();
        drive_cpu(1'b0, 1'b0, 18'h00010, 24'h0, 3'b000);
        drive_dma(1'b0, 1'b0, 18'h00020, 24'h0, 3'b000);
    endtask

    // Both requesters held; returns the 1-based cycle of the first DMA grant and the grant count.
    task automatic contend(input int cycles, output int first, output int grants);
        first = 0;
        grants = 0;
        drive_cpu(1'b1, 1'b0, 18'h00010, 24'h0, 3'b000);
        drive_dma(1'b1, 1'b0, 18'h00020, 24'h0, 3'b000);
        for (int c = 1; c <= cycles; c++) begin
            sample();
            if (bus.dma_gnt) begin
                grants++;
                if (first == 0) begin
                    first = c;
                    chk("forced_cpu_stall", 32'(bus.cpu_stall), 32'd1);
                end
            end
            next_cycle();
        end
    endtask

    int first, grants;

    initial begin
        clk = 0;
        rst = 0;
        n_pass = 0;
        n_total = 0;
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = '0;
            smem[i] = '0;
        end
        bus.ram_q = '0;
        drive_cpu(1'b1, 1'b1, 18'h00010, 24'h123456, 3'b111);
        drive_dma(1'b1, 1'b1, 18'h00020, 24'h654321, 3'b111);
        next_cycle();
        sample();
        chk("reset_wren", 32'(bus.ram_wren), 32'd0);
        chk("reset_gnt", 32'(bus.dma_gnt), 32'd0);
        chk("reset_stall", 32'(bus.cpu_stall), 32'd0);
        next_cycle();
        idle();
        rst = 1;
        next_cycle();

        // Full-word write then read-back.
        drive_cpu(1'b1, 1'b1, 18'h00010, 24'hAABBCC, 3'b111);
        sample();
        chk("cpu_write_wren", 32'(bus.ram_wren), 32'd1);
        chk("cpu_write_stall", 32'(bus.cpu_stall), 32'd0);
        next_cycle();
        drive_cpu(1'b1, 1'b0, 18'h00010, 24'h0, 3'b000);
        next_cycle();
        idle();
        sample();
        chk("cpu_read_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("cpu_read_rdata", 32'(bus.cpu_rdata), 32'hAABBCC);
        next_cycle();

        // Green-lane-only write.
        drive_cpu(1'b1, 1'b1, 18'h00010, 24'h00FF00, 3'b010);
        next_cycle();
        drive_cpu(1'b1, 1'b0, 18'h00010, 24'h0, 3'b000);
        next_cycle();
        idle();
        sample();
        chk("byte_write_rdata", 32'(bus.cpu_rdata), 32'hAAFFCC);
        next_cycle();

        contend(27, first, grants);
        chk("contend_first_grant", 32'(first), 32'd9);
        chk("contend_grant_count", 32'(grants), 32'd3);
        idle();
        next_cycle();

        // Interleaved CPU and DMA reads.
        drive_cpu(1'b1, 1'b1, 18'h00001, 24'h111111, 3'b111);
        next_cycle();
        drive_cpu(1'b1, 1'b1, 18'h00002, 24'h222222, 3'b111);
        next_cycle();
        drive_cpu(1'b1, 1'b0, 18'h00001, 24'h0, 3'b000);
        next_cycle();
        drive_cpu(1'b0, 1'b0, 18'h00001, 24'h0, 3'b000);
        drive_dma(1'b1, 1'b0, 18'h00002, 24'h0, 3'b000);
        sample();
        chk("il_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("il_cpu_rdata", 32'(bus.cpu_rdata), 32'h111111);
        chk("il_dma_rvalid_early", 32'(bus.dma_rvalid), 32'd0);
        next_cycle();
        idle();
        sample();
        chk("il_dma_rvalid", 32'(bus.dma_rvalid), 32'd1);
        chk("il_dma_rdata", 32'(bus.dma_rdata), 32'h222222);
        chk("il_cpu_rvalid_late", 32'(bus.cpu_rvalid), 32'd0);
        chk("il_cpu_rdata_held", 32'(bus.cpu_rdata), 32'h111111);
        next_cycle();

        // CPU read followed by a DMA write to the same word returns the old data.
        drive_cpu(1'b1, 1'b1, 18'h00005, 24'h0A0B0C, 3'b111);
        next_cycle();
        drive_cpu(1'b1, 1'b0, 18'h00005, 24'h0, 3'b000);
        next_cycle();
        drive_cpu(1'b0, 1'b0, 18'h00005, 24'h0, 3'b000);
        drive_dma(1'b1, 1'b1, 18'h00005, 24'h123456, 3'b111);
        sample();
        chk("rdw_old_data", 32'(bus.cpu_rdata), 32'h0A0B0C);
        next_cycle();
        idle();
        drive_cpu(1'b1, 1'b0, 18'h00005, 24'h0, 3'b000);
        next_cycle();
        idle();
        sample();
        chk("rdw_new_data", 32'(bus.cpu_rdata), 32'h123456);
        next_cycle();

        // DMA withdraws exactly in the forced slot.
        drive_cpu(1'b1, 1'b0, 18'h00010, 24'h0, 3'b000);
        drive_dma(1'b1, 1'b0, 18'h00020, 24'h0, 3'b000);
        repeat (8) next_cycle();
        drive_dma(1'b0, 1'b0, 18'h00020, 24'h0, 3'b000);
        sample();
        chk("withdraw_stall", 32'(bus.cpu_stall), 32'd0);
        chk("withdraw_gnt", 32'(bus.dma_gnt), 32'd0);
        chk("withdraw_cpu_served", 32'(bus.ram_byteena), 32'h7);
        next_cycle();
        contend(9, first, grants);
        chk("withdraw_restart_grant", 32'(first), 32'd9);
        idle();
        next_cycle();

        // Reset one cycle after a CPU read is accepted.
        drive_cpu(1'b1, 1'b0, 18'h00010, 24'h0, 3'b000);
        next_cycle();
        drive_cpu(1'b1, 1'b1, 18'h00010, 24'h777777, 3'b111);
        rst = 0;
        #1;
        chk("midrst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("midrst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("midrst_ram_wren", 32'(bus.ram_wren), 32'd0);
        next_cycle();
        next_cycle();
        idle();
        rst = 1;
        sample();
        chk("postrst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        next_cycle();
        next_cycle();
        contend(9, first, grants);
        chk("postrst_first_grant", 32'(first), 32'd9);
        idle();
        repeat (3) next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
